// File: rtl/uart_tx_arbiter.sv
// Packet-based round-robin arbiter that shares one UART TX FIFO among NUM_REQ requesters.
// It also sequences master config requests. Define UART_TX_ARB_BURST_LIMIT_EN to also cap each grant at MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_fifo_write_o,
    input  logic                       tx_fifo_full_i,
    input  logic                       cfg_req_i,
    output logic                       config_req_mst_o,
    input  logic                       req_done_i,
    output logic                       cfg_done_o,
    output logic                       arb_busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_CFG
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic              cfg_pending_q, cfg_pending_d;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              transfer;
    logic              burst_hit;
    logic              grant_end;

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    // Scan from the highest offset down so the last hit is the first valid at or after rr_ptr.
    always_comb begin
        winner    = rr_ptr_q;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign transfer  = (state_q == ARB_GRANT) && req_valid_i[grant_id_q] && !tx_fifo_full_i;
    assign grant_end = transfer && (req_last_i[grant_id_q] || burst_hit);

`ifdef UART_TX_ARB_BURST_LIMIT_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] burst_cnt_q;

    assign burst_hit = (burst_cnt_q == BURST_W'(MAX_BURST - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            burst_cnt_q <= '0;
        end else if (grant_end) begin
            burst_cnt_q <= '0;
        end else if (transfer) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
        end
    end
`else
    assign burst_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_q       <= '0;
            cfg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_q       <= grant_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_d       = grant_q;
        cfg_pending_d = cfg_pending_q;
        case (state_q)
            ARB_IDLE: begin
                if (cfg_pending_q || cfg_req_i) begin
                    state_d       = ARB_CFG;
                    cfg_pending_d = 1'b0;
                end else if (any_valid) begin
                    state_d    = ARB_GRANT;
                    grant_id_d = winner;
                    grant_d    = NUM_REQ'(1) << winner;
                end
            end
            ARB_GRANT: begin
                if (cfg_req_i) begin
                    cfg_pending_d = 1'b1;
                end
                if (grant_end) begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ID_W'((int'(grant_id_q) + 1) % NUM_REQ);
                end
            end
            ARB_CFG: begin
                if (req_done_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == ARB_GRANT && !tx_fifo_full_i) begin
            req_ready_o[grant_id_q] = 1'b1;
        end
        tx_fifo_write_o  = transfer;
        tx_data_o        = transfer ? req_data_i[{grant_id_q, 3'b000} +: 8] : 8'h00;
        config_req_mst_o = (state_q == ARB_CFG);
        cfg_done_o       = (state_q == ARB_CFG) && req_done_i;
        arb_busy_o       = (state_q != ARB_IDLE) || cfg_pending_q;
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter and its TX FIFO among NUM_REQ byte-stream requesters.
- Grants are packet-based and round-robin: each winner holds the TX FIFO write port until its last byte has been written.
- Also sequences master configuration requests: it blocks new grants, drives the transmitter's config-request input and waits for request-done.
- Sits between the client logic and the transmitter's data_tx/tx_fifo_write/config_req_mst/req_done pins.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- MAX_BURST, 16, byte limit per grant; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  NUM_REQ*8  per-requester byte; slice i is [8i+7:8i]
- req_last_i  in  NUM_REQ  byte is last of packet
- req_ready_o  out  NUM_REQ  per-requester accept
- grant_o  out  NUM_REQ  one-hot grant
- grant_id_o  out  $clog2(NUM_REQ)  index of the current or last grantee
- tx_data_o  out  8  byte to TX FIFO
- tx_fifo_write_o  out  1  TX FIFO write strobe
- tx_fifo_full_i  in  1  TX FIFO full
- cfg_req_i  in  1  configuration request pulse
- config_req_mst_o  out  1  to transmitter config-request input
- req_done_i  in  1  transmitter config request finished (1-cycle pulse)
- cfg_done_o  out  1  1-cycle pulse, configuration request complete
- arb_busy_o  out  1  state != ARB_IDLE or cfg_pending

Behaviour:
- Reset values: all outputs 0; state ARB_IDLE; rr_ptr 0; cfg_pending 0; burst_cnt 0.
- cfg_pending:
  - Set by cfg_req_i in ARB_IDLE or ARB_GRANT.
  - Cleared on entry to ARB_CFG.
  - cfg_req_i while in ARB_CFG is ignored (coalesced).
- ARB_IDLE:
  - If cfg_pending (including cfg_req_i this cycle): go to ARB_CFG. Configuration wins over simultaneous valids.
  - Else if any req_valid_i: winner is the first valid index found searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register grant_o and grant_id_o, then go to ARB_GRANT.
  - Grant appears the cycle after the valid is sampled, so first-byte latency is 1 cycle.
- ARB_GRANT:
  - req_ready_o[g] = !tx_fifo_full_i (combinational); all other ready bits are 0.
  - Transfer occurs when req_valid_i[g] & req_ready_o[g]:
    - tx_fifo_write_o = 1;
    - tx_data_o = req_data_i slice g (combinational);
    - burst_cnt increments.
  - Writes never occur while tx_fifo_full_i = 1.
  - A transfer with req_last_i[g] = 1 ends the grant:
    - grant_o is cleared next cycle;
    - rr_ptr = (g+1) mod NUM_REQ with wrap;
    - burst_cnt = 0;
    - go to ARB_IDLE.
  - Requesters must not be re-granted in the same cycle the grant is released; one idle cycle separates packets.
  - A requester dropping valid mid-packet keeps the grant, with no timeout.
- ARB_CFG:
  - config_req_mst_o = 1, held until req_done_i.
  - The transmitter finishes draining its FIFO before it honours the request.
  - On req_done_i: cfg_done_o pulses in the same cycle, config_req_mst_o drops next cycle, go to ARB_IDLE.
  - No grants and all ready bits stay 0 while in this state.
- grant_id_o holds its value outside ARB_GRANT.
- Reset asserted mid-packet or mid-config returns every register to its reset value immediately. A partially written packet is not recovered.

Optional Feature:
- Macro: UART_TX_ARB_BURST_LIMIT_EN.
- Defined:
  - A grant also ends after the transfer that makes burst_cnt == MAX_BURST, even without req_last_i.
  - rr_ptr advances as for a last byte, and the requester re-arbitrates for the remainder of its packet.
  - burst_cnt is $clog2(MAX_BURST+1) bits wide.
- Undefined: grants end only on req_last_i; MAX_BURST is unused.

Test Plan:
- Requester 1 sends a 3-byte packet (0xA1, 0xA2, 0xA3 with last) → grant_o = 0010 the cycle after valid; 3 consecutive tx_fifo_write_o with matching tx_data_o; rr_ptr becomes 2.
- Requesters 0–3 all valid with 1-byte packets from reset → grant order 0, 1, 2, 3, 0; each grant separated by one idle cycle.
- tx_fifo_full_i held high for 5 cycles mid-packet → req_ready_o = 0 and no write during those 5 cycles; the byte is written on the first non-full cycle; data is not lost.
- cfg_req_i pulse during requester 2's 4-byte packet → the packet completes; config_req_mst_o rises the cycle after ARB_IDLE is entered and holds until req_done_i; cfg_done_o pulses once; no grants are issued in between.
- cfg_req_i and req_valid_i[0] in the same ARB_IDLE cycle → config first; requester 0 is granted after cfg_done_o. With UART_TX_ARB_BURST_LIMIT_EN and MAX_BURST = 4, a 6-byte packet from requester 3 with requester 0 also valid → grant ends after 4 bytes, requester 0 is served, then requester 3 sends its remaining 2 bytes.
- rst_n_i asserted mid-packet → grant_o, req_ready_o, tx_fifo_write_o and config_req_mst_o go to 0 asynchronously; after release the next grant starts search at index 0.
